// File: rtl/parity_frame_pkg.sv
// Shared types, defaults and parity helper for the receive-side parity frame checker.
package parity_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 4;
  localparam logic [7:0] ERR_COUNT_MAX = 8'd255;

  // True when the XOR of the data bits and the parity bit matches the selected sense.
  function automatic logic parity_ok(input logic acc, input logic par_bit, input logic odd);
    return ((acc ^ par_bit) == odd);
  endfunction

endpackage

// File: rtl/parity_frame_checker_timeout.sv
// Idle-gap watchdog: counts cycles without a bit while a frame is in progress.
module frame_timeout_counter
  import parity_frame_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Consecutive idle-cycle counter; cleared outside a frame and on every accepted bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!enable || kick) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_LAST) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A bit arriving in the expiry cycle wins, so kick masks the pulse.
  assign expire = enable && !kick && (cnt_r == CNT_LAST);

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, one parity bit.
// Optional saturating error counter enabled by defining PARITY_ERR_COUNTER_EN.
module parity_frame_checker
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ODD_PARITY = 0,
  parameter int TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_done,
  output logic              parity_err,
  output logic              frame_abort,
  output logic              busy
`ifdef PARITY_ERR_COUNTER_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic ODD_L = (ODD_PARITY != 0);

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] shreg_r;
  logic              acc_r;
  logic [DATA_W-1:0] data_out_r;
  logic              frame_done_r;
  logic              parity_err_r;
  logic              frame_abort_r;
  logic              busy_r;
  logic              expire_s;
  logic [DATA_W-1:0] bit_word_s;

  assign bit_word_s = DATA_W'(bit_in);

  frame_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .enable(busy_r),
    .kick  (bit_valid),
    .expire(expire_s)
  );

  // Frame FSM with shift register, running XOR and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= {IDX_W{1'b0}};
      shreg_r       <= {DATA_W{1'b0}};
      acc_r         <= 1'b0;
      data_out_r    <= {DATA_W{1'b0}};
      frame_done_r  <= 1'b0;
      parity_err_r  <= 1'b0;
      frame_abort_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      frame_done_r  <= 1'b0;
      frame_abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bit_valid && !bit_in) begin
            state_r <= DATA;
            idx_r   <= {IDX_W{1'b0}};
            shreg_r <= {DATA_W{1'b0}};
            acc_r   <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        DATA: begin
          if (bit_valid) begin
            // shreg is cleared at the start bit, so OR-ing places each bit at idx.
            shreg_r <= shreg_r | (bit_word_s << idx_r);
            acc_r   <= acc_r ^ bit_in;
            idx_r   <= idx_r + IDX_W'(1);
            if (idx_r == IDX_LAST) begin
              state_r <= PAR;
            end
          end else if (expire_s) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            frame_abort_r <= 1'b1;
          end
        end
        PAR: begin
          if (bit_valid) begin
            data_out_r   <= shreg_r;
            parity_err_r <= !parity_ok(acc_r, bit_in, ODD_L);
            frame_done_r <= 1'b1;
            state_r      <= IDLE;
            busy_r       <= 1'b0;
          end else if (expire_s) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            frame_abort_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = data_out_r;
  assign frame_done  = frame_done_r;
  assign parity_err  = parity_err_r;
  assign frame_abort = frame_abort_r;
  assign busy        = busy_r;

`ifdef PARITY_ERR_COUNTER_EN
  logic [7:0] err_count_r;

  // Saturating count of bad-parity completions and aborts, one cycle after the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_r <= 8'd0;
    end else if (((frame_done_r && parity_err_r) || frame_abort_r) &&
                 (err_count_r != ERR_COUNT_MAX)) begin
      err_count_r <= err_count_r + 8'd1;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`endif

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Receive-side counterpart of the team's XOR/parity generator logic. Accepts a serial frame of start bit, DATA_W data bits and one parity bit, one bit per `bit_valid` strobe. Reassembles the data word and checks parity with a running XOR. Flags mismatches and aborts stalled frames. Sits between a bit source (key sampler or serial link) and the board top, which inverts outputs for the active-low LEDs.

## Interface
- `DATA_W`, default 4: number of data bits per frame, 1..16.
- `ODD_PARITY`, default 0: 0 = even parity (XOR of data and parity bit is 0); 1 = odd parity (XOR is 1).
- `TIMEOUT`, default 1000: maximum idle cycles between accepted bits inside a frame; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `bit_valid` in 1: `bit_in` is sampled this cycle.
- `bit_in` in 1: serial bit.
- `data_out` out DATA_W: last completed frame's data word.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `parity_err` out 1: result for the last completed frame; held until the next completion.
- `frame_abort` out 1: one-cycle pulse on timeout.
- `busy` out 1: high while a frame is in progress.
- `err_count` out 8: saturating error count. Only present with the macro (see Configuration).

## Operation
- States:
  - IDLE
  - DATA: counter `idx` runs 0..DATA_W-1.
  - PAR
- IDLE:
  - `bit_valid && !bit_in` (start bit) → DATA; clears `idx`, the shift register, the running XOR `acc` and the timeout counter.
  - `bit_valid && bit_in` is ignored (line idle high).
- DATA, on each `bit_valid`:
  - `shreg[idx] <= bit_in` (LSB first).
  - `acc <= acc ^ bit_in`.
  - `idx` increments.
  - On `idx == DATA_W-1` → PAR.
- PAR, on `bit_valid`:
  - `data_out <= shreg` including the current-cycle-free assembled word.
  - `parity_err <= (acc ^ bit_in) != ODD_PARITY`.
  - Pulse `frame_done`.
  - → IDLE.
- Timeout, in DATA or PAR:
  - The counter increments on every cycle without `bit_valid` and resets on `bit_valid`.
  - When it reaches TIMEOUT-1 without a bit: pulse `frame_abort` and go to IDLE.
  - `data_out` and `parity_err` are left unchanged.
- Simultaneous events:
  - `bit_valid` in the same cycle the counter would expire: the bit wins and no abort occurs.
  - A start bit arriving in the cycle after `frame_done` or `frame_abort` is accepted; there is no dead cycle.
- `reset` asserted at any time, mid-frame included: returns to IDLE and discards the partial frame.
- Width rules:
  - `idx` is $clog2(DATA_W+1) bits.
  - The timeout counter is $clog2(TIMEOUT) bits.
  - `acc` is 1 bit.

## Timing
- Reset values:
  - `data_out` = 0
  - `parity_err` = 0
  - `frame_done` = 0
  - `frame_abort` = 0
  - `busy` = 0
  - `err_count` = 0
- `busy` is registered: it goes high the cycle after the start bit and low the cycle after the parity bit or the abort.
- Latency: `frame_done`, `data_out` and `parity_err` update on the clock edge that samples the parity bit, so they are visible the next cycle.
- `frame_done` and `frame_abort` are never high in the same cycle.
- `bit_valid` may be asserted back-to-back every cycle. The minimum frame is DATA_W+2 cycles.

## Configuration
- `PARITY_ERR_COUNTER_EN` defined:
  - `err_count` port exists.
  - It increments on each `frame_done` with a parity error and saturates at 255.
  - `frame_abort` also counts.
  - It is cleared only by `reset`.
- `PARITY_ERR_COUNTER_EN` not defined: port and logic are absent. All other behaviour is identical.

## Structure
- Package `parity_frame_pkg`:
  - `state_t` enum (IDLE, DATA, PAR).
  - Localparam for the default data width.
  - Function `parity_ok(acc, par_bit, odd)`, shared with the generator side.
- One sub-module, `frame_timeout_counter`:
  - Inputs: `clk`, `reset`, `enable` (busy), `kick` (bit_valid).
  - Output: `expire` pulse.
  - Parameter: TIMEOUT.
- The FSM, shift register and accumulator stay in the top module.

## Test plan
- Even parity, DATA_W=4. Bits 0,1,1,0,1 then parity 1 (data 4'b1011, three ones), back-to-back → `frame_done` one cycle after the parity bit, `data_out`=4'hB, `parity_err`=0.
- Same frame with parity bit 0 → `parity_err`=1; with `PARITY_ERR_COUNTER_EN`, `err_count` 0→1.
- ODD_PARITY=1, data 4'h0, parity 1 → `parity_err`=0. Same data with parity 0 → `parity_err`=1.
- Start bit plus 2 data bits, then no `bit_valid` for TIMEOUT cycles → single `frame_abort` pulse, `busy`=0, `data_out` keeps its prior value 4'hB.
- Idle-high bits (`bit_in`=1) in IDLE, then `reset` pulsed mid-frame after 3 data bits, then a full valid frame 4'h5 → no `frame_done` before the reset; after the reset, `data_out`=4'h5 with `parity_err`=0.
- Stall: `bit_valid` exactly at cycle TIMEOUT-1 of a gap → no abort, frame completes normally.
